param_seq_mult: RTL and testbench

PARAM_SEQ_MULT -- requirements
Module: param_seq_mult

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/seq_mult_pp_add.sv | 35 +++
 rtl/param_seq_mult.sv | 104 ++++++++++
 tb/tb_param_seq_mult.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and default widths for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_MX_W = 16;
    localparam int DEF_MY_W = 9;

endpackage

// File: rtl/seq_mult_pp_add.sv
// Partial-product select plus (MX_W+1)-bit add/subtract for one shift-add step.
// Two's complement operation is enabled by defining PARAM_SEQ_MULT_SIGNED_EN.
module seq_mult_pp_add
    import seq_mult_pkg::*;
#(
    parameter int MX_W = DEF_MX_W
) (
    input  logic [MX_W-1:0] acc_hi,
    input  logic [MX_W-1:0] mx,
    input  logic            my_lsb,
    input  logic            last,
    output logic [MX_W:0]   sum
);

`ifdef PARAM_SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic signed [MX_W:0] acc_ext;
    logic signed [MX_W:0] pp_ext;

    // In signed mode the multiplier MSB carries negative weight, so the last step subtracts.
    always_comb begin
        acc_ext = $signed({SIGNED_MODE & acc_hi[MX_W-1], acc_hi});
        pp_ext  = my_lsb ? $signed({SIGNED_MODE & mx[MX_W-1], mx}) : '0;
        if (SIGNED_MODE && last) begin
            sum = $unsigned(acc_ext - pp_ext);
        end else begin
            sum = $unsigned(acc_ext + pp_ext);
        end
    end

endmodule

// File: rtl/param_seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, MY_W cycles per product.
// Define PARAM_SEQ_MULT_SIGNED_EN for two's complement operands (same latency).
module param_seq_mult
    import seq_mult_pkg::*;
#(
    parameter int MX_W = DEF_MX_W,
    parameter int MY_W = DEF_MY_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MX_W-1:0]      in_Mx,
    input  logic [MY_W-1:0]      in_My,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MX_W+MY_W-1:0] Prod,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MY_W + 1);

    state_t           state;
    state_t           state_next;
    logic [MX_W-1:0]  mx;
    logic [MY_W-1:0]  my;
    logic [MX_W:0]    acc;
    logic [MY_W-1:0]  low;
    logic [CNT_W-1:0] cnt;
    logic [MX_W:0]    sum;
    logic             last;
    logic             accept;

    assign last = (cnt == CNT_W'(MY_W - 1));

    seq_mult_pp_add #(
        .MX_W(MX_W)
    ) u_pp_add (
        .acc_hi(acc[MX_W:1]),
        .mx    (mx),
        .my_lsb(my[0]),
        .last  (last),
        .sum   (sum)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        Prod       = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = RESET;
                accept   = in_valid && RESET;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // acc holds the unshifted final sum, so its upper MX_W bits are the shifted result
                Prod      = {acc[MX_W:1], low};
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            mx    <= '0;
            my    <= '0;
            acc   <= '0;
            low   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mx  <= in_Mx;
                my  <= in_My;
                acc <= '0;
                low <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                acc <= sum;
                low <= {sum[0], low[MY_W-1:1]};
                my  <= my >> 1;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_seq_mult.sv
// Bench for param_seq_mult: default 16x9 instance plus an 8x4 instance.
// Expected values follow PARAM_SEQ_MULT_SIGNED_EN when it is defined.
module tb_param_seq_mult;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_Mx;
    logic [8:0]  in_My;
    logic [24:0] Prod;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [7:0]  in_Mx_b;
    logic [3:0]  in_My_b;
    logic [11:0] Prod_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic ov_prev = 1'b0;
    logic [24:0] exp_q[$];
    logic [11:0] qb[$];

    typedef struct {
        logic [15:0] mx;
        logic [8:0]  my;
        logic [24:0] exp;
    } vec_a_t;

    typedef struct {
        logic [7:0]  mx;
        logic [3:0]  my;
        logic [11:0] exp;
    } vec_b_t;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    param_seq_mult u_dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_Mx(in_Mx), .in_My(in_My), .out_valid(out_valid), .out_ready(out_ready),
        .Prod(Prod), .busy(busy)
    );

    param_seq_mult #(.MX_W(8), .MY_W(4)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_Mx(in_Mx_b), .in_My(in_My_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .Prod(Prod_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference product: plain integer multiply, operands optionally sign-interpreted.
    function automatic logic [63:0] model(input logic [63:0] mx, input logic [63:0] my,
                                          input int wx, input int wy);
        longint a, b;
        a = longint'(mx);
        b = longint'(my);
`ifdef PARAM_SEQ_MULT_SIGNED_EN
        if (mx[wx-1]) a = a - (longint'(1) << wx);
        if (my[wy-1]) b = b - (longint'(1) << wy);
`endif
        return 64'((a * b) & ((longint'(1) << (wx + wy)) - 1));
    endfunction

    always @(negedge CLK) begin
        #2;
        if (RESET) begin
            check("onehot_ctrl", 64'($countones({in_ready, busy, out_valid})), 64'd1);
            if (!out_valid) check("prod_zero_not_done", 64'(Prod), 64'd0);
            if (out_valid && !ov_prev) check("latency", 64'(cyc - acc_cyc), 64'd9);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
                else check("prod", 64'(Prod), 64'(exp_q.pop_front()));
            end
        end
        ov_prev = out_valid;
    end

    task automatic issue(input logic [15:0] mx, input logic [8:0] my, input logic [24:0] exp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            return;
        end
        in_Mx = mx;
        in_My = my;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        acc_cyc = cyc + 1;
        @(negedge CLK);
        in_valid = 1'b0;
        in_Mx = 16'($urandom);
        in_My = 9'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_a_t va[10];
        vec_b_t vb[4];
        logic [24:0] held;
        int n;
        int k;
        int got;
        int last_ov;
        int b_acc;

`ifdef PARAM_SEQ_MULT_SIGNED_EN
        va[0] = '{16'hFFFF, 9'h1FF, 25'h0000001};
        va[1] = '{16'h8000, 9'h100, 25'h0800000};
        va[2] = '{16'h0003, 9'h1FE, 25'h1FFFFFA};
        vb[0] = '{8'hFF, 4'hF, 12'h001};
`else
        va[0] = '{16'hFFFF, 9'h1FF, 25'h1FEFE01};
        va[1] = '{16'h8000, 9'h100, 25'h0800000};
        va[2] = '{16'h0003, 9'h1FE, 25'h00005FA};
        vb[0] = '{8'hFF, 4'hF, 12'hEF1};
`endif
        va[3] = '{16'h0000, 9'h1FF, 25'h0000000};
        va[4] = '{16'h1234, 9'h000, 25'h0000000};
        va[5] = '{16'h0002, 9'h003, 25'h0000006};
        va[6] = '{16'h7FFF, 9'h0FF, 25'(model(64'h7FFF, 64'h0FF, 16, 9))};
        va[7] = '{16'hABCD, 9'h155, 25'(model(64'hABCD, 64'h155, 16, 9))};
        va[8] = '{16'h0001, 9'h1FF, 25'(model(64'h0001, 64'h1FF, 16, 9))};
        va[9].mx = 16'($urandom);
        va[9].my = 9'($urandom);
        va[9].exp = 25'(model(64'(va[9].mx), 64'(va[9].my), 16, 9));
        vb[1] = '{8'h00, 4'h9, 12'h000};
        vb[2] = '{8'h80, 4'h8, 12'(model(64'h80, 64'h8, 8, 4))};
        vb[3] = '{8'h5A, 4'h3, 12'(model(64'h5A, 64'h3, 8, 4))};

        RESET = 1'b0;
        in_valid = 1'b0; in_Mx = '0; in_My = '0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_Mx_b = '0; in_My_b = '0; out_ready_b = 1'b1;

        // Reset state, with in_valid offered to confirm in_ready stays gated.
        repeat (3) @(negedge CLK);
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_prod", 64'(Prod), 64'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        check("rst_busy_after_valid", 64'(busy), 64'd0);
        RESET = 1'b1;
        #1;
        check("rst_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            issue(va[i].mx, va[i].my, va[i].exp);
            drain();
        end

        // Backpressure: junk in_valid offers during RUN and while DONE is held.
        out_ready = 1'b0;
        issue(16'h1357, 9'h0A5, 25'(model(64'h1357, 64'h0A5, 16, 9)));
        n = 0;
        while (!out_valid && n < 30) begin
            in_valid = 1'b1;
            in_Mx = 16'hFFFF;
            in_My = 9'h1FF;
            @(negedge CLK);
            n++;
        end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        held = Prod;
        check("bp_prod_value", 64'(held), model(64'h1357, 64'h0A5, 16, 9));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_Mx = 16'(i + 1);
            in_My = 9'(i + 1);
            @(negedge CLK);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_prod_stable", 64'(Prod), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during RUN aborts the operation with no result.
        issue(16'h1234, 9'h0AB, 25'(model(64'h1234, 64'h0AB, 16, 9)));
        repeat (3) @(negedge CLK);
        check("abort_busy_before", 64'(busy), 64'd1);
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_prod", 64'(Prod), 64'd0);
        check("abort_in_ready_gated", 64'(in_ready), 64'd0);
        exp_q.delete();
        RESET = 1'b1;
        #1;
        check("abort_idle", 64'(in_ready), 64'd1);
        @(negedge CLK);
        issue(16'h0002, 9'h003, 25'h0000006);
        drain();

        // 8x4 instance: back-to-back operations with in_valid held high.
        k = 0; got = 0; last_ov = -1; n = 0; b_acc = 0;
        while (got < 4 && n < 100) begin
            @(negedge CLK);
            n++;
            check("b_onehot", 64'($countones({in_ready_b, busy_b, out_valid_b})), 64'd1);
            if (out_valid_b) begin
                if (qb.size() == 0) check("b_unexpected_out", 64'd1, 64'd0);
                else check("b_prod", 64'(Prod_b), 64'(qb.pop_front()));
                if (last_ov < 0) check("b_latency", 64'(cyc - b_acc), 64'd4);
                else check("b_spacing", 64'(cyc - last_ov), 64'd6);
                last_ov = cyc;
                got++;
            end else begin
                check("b_prod_zero", 64'(Prod_b), 64'd0);
            end
            if (in_ready_b && k < 4) begin
                in_Mx_b = vb[k].mx;
                in_My_b = vb[k].my;
                in_valid_b = 1'b1;
                qb.push_back(vb[k].exp);
                if (k == 0) b_acc = cyc + 1;
                k++;
            end else if (k >= 4) begin
                in_valid_b = 1'b0;
            end
        end
        check("b_results_seen", 64'(got), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
